rr_mux_sel_scheduler_4ch: RTL
=============================

Name: rr_mux_sel_scheduler_4ch

Overview:
- Round-robin scheduler that generates the 2-bit select for the team's 4:1 data muxes (d_in[3:0], sel_in[1:0], y_out).
- Sits directly upstream of the mux: the mux's sel_in is driven from sel_out.
- Arbitrates four request lines and holds each grant for a programmable dwell time.
- valid_out marks the cycles in which the mux output carries a granted channel.

Parameters:
- DWELL, 4, maximum number of consecutive cycles a grant is held. Legal range 1..255.
- CNT_W, 8, width of the dwell counter. Must satisfy 2^CNT_W > DWELL-1.

Ports:
- clk_in  input  1  single clock; all logic is on the rising edge.
- rst_in  input  1  synchronous reset, active-high.
- en_in  input  1  scheduler enable. Low forces release and idle.
- req_in  input  4  per-channel request; bit i requests channel i.
- sel_out  output  2  mux select; binary index of the granted channel.
- grant_out  output  4  one-hot grant; equals 1<<sel_out while valid_out=1, otherwise 0.
- valid_out  output  1  high while a grant is active.

Behaviour:
- Reset (rst_in high at a rising edge):
  - sel_out=0, grant_out=0, valid_out=0, state IDLE.
  - Dwell counter=0; last-served pointer=3, so channel 0 has first priority.
  - Reset overrides everything, including a grant in progress.
- All outputs are registered. Latency from a request being sampled to valid_out=1 is 1 cycle.
- Priority search: scan channels starting at (last+1) mod 4, ascending with wrap, and pick the first set bit of req_in. The last-served channel has lowest priority but is still eligible.
- State IDLE:
  - If en_in=1 and req_in!=0, grant the winner at the next edge: sel_out=winner, grant_out=onehot(winner), valid_out=1, counter=DWELL-1, state GRANT.
  - Otherwise remain in IDLE.
- State GRANT: each edge evaluates the end condition E = (counter==0) OR (req_in[sel_out]==0) OR (en_in==0).
  - If E is false: counter decrements; all outputs hold.
  - If E is true: last=sel_out, then re-arbitrate in the same cycle using the updated pointer.
  - If en_in=1 and a winner exists: back-to-back grant with no idle bubble. The new sel_out, grant_out and counter=DWELL-1 take effect at that edge, and valid_out stays 1.
  - If en_in=1 and no winner exists, or en_in=0: valid_out=0, grant_out=0, state IDLE.
- sel_out holds its last value while valid_out=0, so the mux output does not glitch.
- A dropped request still shows valid_out=1 in the cycle it is sampled low; the grant ends at the following edge.
- If only the current channel is requesting when E is true due to dwell expiry, it is re-granted (wrap to itself) with a fresh dwell.
- DWELL=1: counter is loaded with 0, so every grant lasts exactly 1 cycle and channels rotate each cycle.
- Invariants:
  - grant_out is always zero or one-hot.
  - grant_out != 0 if and only if valid_out=1.
  - No channel is granted unless its req_in bit was high at the granting edge.

Test Plan:
- Reset/idle: DWELL=4; assert rst_in mid-grant with req_in=4'b1111 → next cycle sel_out=0, grant_out=0, valid_out=0; after release, channel 0 is granted first.
- Full rotation: DWELL=4, req_in=4'b1111 held from cycle 0 → valid_out=1 from cycle 1 with no gaps; sel_out = 0 for cycles 1–4, 1 for 5–8, 2 for 9–12, 3 for 13–16, then 0 again at cycle 17.
- Early release and skip: req_in=4'b0101; clear bit 0 two cycles into channel 0's grant → channel 0 is held 3 cycles total, then sel_out=2 back-to-back; channels 1 and 3 are never granted.
- Single requester re-grant and wrap: req_in=4'b1000 held, DWELL=4 → sel_out=3 continuously, grant_out=4'b1000, valid_out never drops. Then set req_in=4'b1001 → after the current dwell expires, sel_out=0 (wrap from 3).
- Enable drop: en_in=0 during a grant → valid_out=0 and grant_out=0 at the next edge, sel_out holds. en_in=1 with req_in=4'b1111 → the grant resumes at last+1.
- DWELL=1 build: req_in=4'b1111 → sel_out sequence 0,1,2,3,0,… one cycle each, valid_out constantly 1.

Source files
------------

// File: rtl/rr_mux_sel_scheduler_4ch.sv
// Round-robin select generator for a 4:1 data mux. It grants one requesting
// channel at a time and holds the grant for up to DWELL cycles. Every output
// is registered, and sel_out keeps its value while idle so the mux output
// does not glitch.
module rr_mux_sel_scheduler_4ch #(
  parameter int DWELL = 4,
  parameter int CNT_W = 8
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       en_in,
  input  logic [3:0] req_in,
  output logic [1:0] sel_out,
  output logic [3:0] grant_out,
  output logic       valid_out
);

  localparam int NUM_CH = 4;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DWELL - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       last;

  logic       end_grant;
  logic [1:0] arb_ptr;
  logic       win_vld;
  logic [1:0] win_idx;

  // Scan from ptr+1 upward with wrap. The loop runs from the farthest
  // candidate to the nearest, so the nearest requester is written last and wins.
  function automatic logic [2:0] pick(input logic [3:0] req, input logic [1:0] ptr);
    logic [2:0] res;
    logic [1:0] c;
    res = 3'b000;
    for (int k = NUM_CH; k >= 1; k--) begin
      c = ptr + 2'(k);
      if (req[c]) res = {1'b1, c};
    end
    return res;
  endfunction

  // End-of-grant condition and arbitration. While a grant is active,
  // sel_out is the channel that becomes "last" at this edge.
  always_comb begin
    end_grant          = (cnt == '0) || !req_in[sel_out] || !en_in;
    arb_ptr            = (state == GRANT) ? sel_out : last;
    {win_vld, win_idx} = pick(req_in, arb_ptr);
  end

  // Scheduler FSM with registered outputs.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state     <= IDLE;
      cnt       <= '0;
      last      <= 2'd3;
      sel_out   <= 2'd0;
      grant_out <= 4'b0000;
      valid_out <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (en_in && win_vld) begin
            sel_out   <= win_idx;
            grant_out <= 4'b0001 << win_idx;
            valid_out <= 1'b1;
            cnt       <= CNT_LOAD;
            state     <= GRANT;
          end
        end
        GRANT: begin
          if (!end_grant) begin
            cnt <= cnt - 1'b1;
          end else begin
            last <= sel_out;
            if (en_in && win_vld) begin
              // Back-to-back grant: valid_out stays high, so there is no idle bubble.
              sel_out   <= win_idx;
              grant_out <= 4'b0001 << win_idx;
              cnt       <= CNT_LOAD;
            end else begin
              grant_out <= 4'b0000;
              valid_out <= 1'b0;
              state     <= IDLE;
            end
          end
        end
      endcase
    end
  end

endmodule
